// File: rtl/cache_arbiter_if.sv
// Bundle of client, memory and arbiter-facing signals for the cacheline port arbiter.
// slave = arbiter view, master = surrounding clients/memory view.
interface cache_arbiter_if #(
   parameter int unsigned cacheline_size = 256
);
   logic [31:0]               from_icache_address;
   logic                      from_icache_read;
   logic [cacheline_size-1:0] to_icache_rdata;
   logic                      to_icache_resp;

   logic [31:0]               from_dcache_address;
   logic                      from_dcache_read;
   logic                      from_dcache_write;
   logic [cacheline_size-1:0] from_dcache_wdata;
   logic [cacheline_size-1:0] to_dcache_rdata;
   logic                      to_dcache_resp;

   logic [31:0]               to_mem_address;
   logic                      to_mem_read;
   logic                      to_mem_write;
   logic [cacheline_size-1:0] to_mem_wdata;
   logic [cacheline_size-1:0] from_mem_rdata;
   logic                      from_mem_resp;

   modport slave (
      input  from_icache_address, from_icache_read,
      output to_icache_rdata, to_icache_resp,
      input  from_dcache_address, from_dcache_read, from_dcache_write, from_dcache_wdata,
      output to_dcache_rdata, to_dcache_resp,
      output to_mem_address, to_mem_read, to_mem_write, to_mem_wdata,
      input  from_mem_rdata, from_mem_resp
   );

   modport master (
      output from_icache_address, from_icache_read,
      input  to_icache_rdata, to_icache_resp,
      output from_dcache_address, from_dcache_read, from_dcache_write, from_dcache_wdata,
      input  to_dcache_rdata, to_dcache_resp,
      input  to_mem_address, to_mem_read, to_mem_write, to_mem_wdata,
      output from_mem_rdata, from_mem_resp
   );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and the
// D-side eviction buffer; the winning request is latched and held until memory responds.
module cache_arbiter #(
   parameter int unsigned cacheline_size = 256
) (
   input  logic           clk,
   input  logic           rst,
   cache_arbiter_if.slave bus
);
   localparam int unsigned AddrW = 32;
   localparam int unsigned LineW = cacheline_size;

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_e;

   state_e             state_q, state_d;
   logic               last_d_q, last_d_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic [LineW-1:0]   wdata_q, wdata_d;

   logic ireq_c, dreq_c, grant_i_c, grant_d_c, i_resp_c, d_resp_c;

   // On a tie the side that did not win last time is granted
   assign ireq_c    = bus.from_icache_read;
   assign dreq_c    = bus.from_dcache_read | bus.from_dcache_write;
   assign grant_i_c = ireq_c & (~dreq_c | last_d_q);
   assign grant_d_c = dreq_c & (~ireq_c | ~last_d_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_i_c) begin
               state_d  = I_BUSY;
               last_d_d = 1'b0;
               addr_d   = bus.from_icache_address;
               rd_d     = 1'b1;
               wr_d     = 1'b0;
               wdata_d  = '0;
            end else if (grant_d_c) begin
               // A simultaneous read and write from the D side is a write-back
               state_d  = D_BUSY;
               last_d_d = 1'b1;
               addr_d   = bus.from_dcache_address;
               rd_d     = ~bus.from_dcache_write;
               wr_d     = bus.from_dcache_write;
               wdata_d  = bus.from_dcache_wdata;
            end
         end
         I_BUSY, D_BUSY: begin
            if (bus.from_mem_resp) begin
               state_d = IDLE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   assign i_resp_c = (state_q == I_BUSY) & bus.from_mem_resp;
   assign d_resp_c = (state_q == D_BUSY) & bus.from_mem_resp;

   assign bus.to_icache_resp  = i_resp_c;
   assign bus.to_icache_rdata = i_resp_c ? bus.from_mem_rdata : '0;
   assign bus.to_dcache_resp  = d_resp_c;
   assign bus.to_dcache_rdata = d_resp_c ? bus.from_mem_rdata : '0;

   assign bus.to_mem_address = addr_q;
   assign bus.to_mem_read    = rd_q;
   assign bus.to_mem_write   = wr_q;
   assign bus.to_mem_wdata   = wdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed per-cycle vector table plus a bounded latency sequence for cache_arbiter.
module tb_cache_arbiter;
   localparam int unsigned LineW = 256;
   localparam int          NVec  = 32;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   cache_arbiter_if #(.cacheline_size(LineW)) bus ();

   cache_arbiter #(.cacheline_size(LineW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ird;
      logic [31:0] iad;
      logic        drd;
      logic        dwr;
      logic [31:0] dad;
      logic [31:0] dwd;
      logic        mresp;
      logic [31:0] mrd;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_ad;
      logic [31:0] e_wd;
      logic        e_ir;
      logic [31:0] e_ird;
      logic        e_dr;
      logic [31:0] e_drd;
   } vec_t;

   vec_t tbl [NVec];

   function automatic logic [LineW-1:0] line(input logic [31:0] w);
      return {8{w}};
   endfunction

   function automatic vec_t mk(
      input logic r, input logic ird, input logic [31:0] iad,
      input logic drd, input logic dwr, input logic [31:0] dad, input logic [31:0] dwd,
      input logic mresp, input logic [31:0] mrd,
      input logic e_rd, input logic e_wr, input logic [31:0] e_ad, input logic [31:0] e_wd,
      input logic e_ir, input logic [31:0] e_ird, input logic e_dr, input logic [31:0] e_drd);
      vec_t v;
      v.rst = r;       v.ird = ird;     v.iad = iad;
      v.drd = drd;     v.dwr = dwr;     v.dad = dad;     v.dwd = dwd;
      v.mresp = mresp; v.mrd = mrd;
      v.e_rd = e_rd;   v.e_wr = e_wr;   v.e_ad = e_ad;   v.e_wd = e_wd;
      v.e_ir = e_ir;   v.e_ird = e_ird; v.e_dr = e_dr;   v.e_drd = e_drd;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [LineW-1:0] act,
                      input logic [LineW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst                     = v.rst;
      bus.from_icache_read    = v.ird;
      bus.from_icache_address = v.iad;
      bus.from_dcache_read    = v.drd;
      bus.from_dcache_write   = v.dwr;
      bus.from_dcache_address = v.dad;
      bus.from_dcache_wdata   = line(v.dwd);
      bus.from_mem_resp       = v.mresp;
      bus.from_mem_rdata      = line(v.mrd);
   endtask

   // Invariants checked every cycle, mid-low-phase so inputs have settled
   always begin
      @(negedge clk);
      #2;
      if (rst === 1'b0) begin
         total++;
         if ((bus.to_mem_read & bus.to_mem_write) | (bus.to_icache_resp & bus.to_dcache_resp)) begin
            bad++;
            $display("FAIL exclusive: rd=%b wr=%b iresp=%b dresp=%b", bus.to_mem_read,
                     bus.to_mem_write, bus.to_icache_resp, bus.to_dcache_resp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      clk = 1'b0;
      drive(mk(1, 0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0));

      // idle after reset, then an I read with response after five busy cycles
      tbl[0]  = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,32'h0);
      tbl[1]  = mk(0, 1,32'h1000,   0,0,32'h0,32'h0,              0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,32'h0);
      tbl[2]  = mk(0, 1,32'h1000,   0,0,32'h0,32'h0,              0,32'h0,      1,0,32'h1000,32'h0,           0,32'h0,      0,32'h0);
      tbl[3]  = tbl[2];
      tbl[4]  = tbl[2];
      tbl[5]  = tbl[2];
      tbl[6]  = mk(0, 1,32'h1000,   0,0,32'h0,32'h0,              1,32'hA5A5A5A5, 1,0,32'h1000,32'h0,         1,32'hA5A5A5A5, 0,32'h0);
      tbl[7]  = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,0,32'h1000,32'h0,           0,32'h0,      0,32'h0);
      // D write-back; wdata changes under it
      tbl[8]  = mk(0, 0,32'h0,      0,1,32'h2000,32'hDEADBEEF,    0,32'h0,      0,0,32'h1000,32'h0,           0,32'h0,      0,32'h0);
      tbl[9]  = mk(0, 0,32'h0,      0,1,32'h2000,32'h12345678,    0,32'h0,      0,1,32'h2000,32'hDEADBEEF,    0,32'h0,      0,32'h0);
      tbl[10] = mk(0, 0,32'h0,      0,1,32'h2000,32'h12345678,    1,32'hFFFF0000, 0,1,32'h2000,32'hDEADBEEF,  0,32'h0,      1,32'hFFFF0000);
      tbl[11] = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,0,32'h2000,32'hDEADBEEF,    0,32'h0,      0,32'h0);
      // reset, then ties alternate starting with I
      tbl[12] = mk(1, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,0,32'h2000,32'hDEADBEEF,    0,32'h0,      0,32'h0);
      tbl[13] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,32'h0);
      tbl[14] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           1,32'h11111111, 1,0,32'h3000,32'h0,         1,32'h11111111, 0,32'h0);
      tbl[15] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           0,32'h0,      0,0,32'h3000,32'h0,           0,32'h0,      0,32'h0);
      tbl[16] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           0,32'h0,      1,0,32'h4000,32'h0,           0,32'h0,      0,32'h0);
      tbl[17] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           1,32'h22222222, 1,0,32'h4000,32'h0,         0,32'h0,      1,32'h22222222);
      tbl[18] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           0,32'h0,      0,0,32'h4000,32'h0,           0,32'h0,      0,32'h0);
      tbl[19] = mk(0, 1,32'h3000,   1,0,32'h4000,32'h0,           1,32'h33333333, 1,0,32'h3000,32'h0,         1,32'h33333333, 0,32'h0);
      // D read, then write-back queued behind the pending I read
      tbl[20] = mk(0, 1,32'h5000,   1,0,32'h6000,32'h0,           0,32'h0,      0,0,32'h3000,32'h0,           0,32'h0,      0,32'h0);
      tbl[21] = mk(0, 1,32'h5000,   1,0,32'h6000,32'h0,           1,32'h44444444, 1,0,32'h6000,32'h0,         0,32'h0,      1,32'h44444444);
      tbl[22] = mk(0, 1,32'h5000,   0,1,32'h7000,32'hCAFEF00D,    0,32'h0,      0,0,32'h6000,32'h0,           0,32'h0,      0,32'h0);
      tbl[23] = mk(0, 1,32'h5000,   0,1,32'h7000,32'hCAFEF00D,    1,32'h55555555, 1,0,32'h5000,32'h0,         1,32'h55555555, 0,32'h0);
      tbl[24] = mk(0, 0,32'h0,      0,1,32'h7000,32'hCAFEF00D,    0,32'h0,      0,0,32'h5000,32'h0,           0,32'h0,      0,32'h0);
      tbl[25] = mk(0, 0,32'h0,      0,1,32'h7000,32'hCAFEF00D,    1,32'h9ABCDEF0, 0,1,32'h7000,32'hCAFEF00D,  0,32'h0,      1,32'h9ABCDEF0);
      // spurious resp in IDLE, read+write treated as write, client drop, reset while busy
      tbl[26] = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              1,32'h66666666, 0,0,32'h7000,32'hCAFEF00D,  0,32'h0,      0,32'h0);
      tbl[27] = mk(0, 0,32'h0,      1,1,32'h8000,32'h77777777,    0,32'h0,      0,0,32'h7000,32'hCAFEF00D,    0,32'h0,      0,32'h0);
      tbl[28] = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,1,32'h8000,32'h77777777,    0,32'h0,      0,32'h0);
      tbl[29] = mk(1, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,1,32'h8000,32'h77777777,    0,32'h0,      0,32'h0);
      tbl[30] = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              1,32'h88888888, 0,0,32'h0,32'h0,            0,32'h0,      0,32'h0);
      tbl[31] = mk(0, 0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,0,32'h0,32'h0,              0,32'h0,      0,32'h0);

      repeat (2) @(posedge clk);

      for (int i = 0; i < NVec; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk("mem_read",     i, LineW'(bus.to_mem_read),     LineW'(tbl[i].e_rd));
         chk("mem_write",    i, LineW'(bus.to_mem_write),    LineW'(tbl[i].e_wr));
         chk("mem_address",  i, LineW'(bus.to_mem_address),  LineW'(tbl[i].e_ad));
         chk("mem_wdata",    i, bus.to_mem_wdata,            line(tbl[i].e_wd));
         chk("icache_resp",  i, LineW'(bus.to_icache_resp),  LineW'(tbl[i].e_ir));
         chk("icache_rdata", i, bus.to_icache_rdata,         line(tbl[i].e_ird));
         chk("dcache_resp",  i, LineW'(bus.to_dcache_resp),  LineW'(tbl[i].e_dr));
         chk("dcache_rdata", i, bus.to_dcache_rdata,         line(tbl[i].e_drd));
      end

      // Strobe latency after a fresh request, bounded wait
      @(negedge clk);
      drive(mk(0, 1,32'h9000, 0,0,32'h0,32'h0, 0,32'h0, 0,0,0,0, 0,0,0,0));
      lat = 0;
      while (bus.to_mem_read !== 1'b1 && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("read_latency", 100, LineW'(lat), LineW'(1));
      chk("latency_addr", 100, LineW'(bus.to_mem_address), LineW'(32'h9000));

      // Client drops its request; the response still arrives
      @(negedge clk);
      drive(mk(0, 0,32'h0, 0,0,32'h0,32'h0, 1,32'h0BADF00D, 0,0,0,0, 0,0,0,0));
      #1;
      chk("drop_iresp",  101, LineW'(bus.to_icache_resp), LineW'(1));
      chk("drop_irdata", 101, bus.to_icache_rdata,        line(32'h0BADF00D));
      chk("drop_dresp",  101, LineW'(bus.to_dcache_resp), LineW'(0));
      @(negedge clk);
      drive(mk(0, 0,32'h0, 0,0,32'h0,32'h0, 0,32'h0, 0,0,0,0, 0,0,0,0));
      #1;
      chk("strobe_clear", 102, LineW'(bus.to_mem_read),   LineW'(0));
      chk("resp_clear",   102, LineW'(bus.to_icache_resp), LineW'(0));

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
